maxpool_cif_udiv_seq: RTL and testbench
=======================================

// Module: maxpool_cif_udiv_seq
// PURPOSE
//  Sequential unsigned restoring divider: the inverse of the pooling datapath's
//  pipelined unsigned multiplier.
//  - Splits a flat feature-map index into row (quotient) and column (remainder)
//    for a runtime line width.
//  - Produces one quotient bit per enabled cycle, with a start/done handshake.
//  - Sits beside the maxpool address generator and feeds the window row/col counters.
// PARAMETERS
//  DIVIDEND_WIDTH  63  dividend and quotient width (bits)
//  DIVISOR_WIDTH   31  divisor and remainder width (bits); must be <= DIVIDEND_WIDTH
// PORTS
//  clk          in   1               rising-edge clock
//  reset_n      in   1               asynchronous, active-low reset
//  ce           in   1               clock enable; 0 freezes all state and outputs
//  start        in   1               request; accepted only when ce=1 and ready=1
//  dividend     in   DIVIDEND_WIDTH  unsigned dividend, sampled on accept
//  divisor      in   DIVISOR_WIDTH   unsigned divisor, sampled on accept
//  ready        out  1               1 in IDLE and DONE: can accept start
//  done         out  1               one-cycle pulse: results valid
//  quotient     out  DIVIDEND_WIDTH  floor(dividend/divisor); held until next accept
//  remainder    out  DIVISOR_WIDTH   dividend mod divisor; held until next accept
//  div_by_zero  out  1               set with done when the sampled divisor was 0
// BEHAVIOUR
//  - Clock and reset: one clock domain; reset_n is asynchronous, active-low.
//  - Reset values: state=IDLE, ready=1, done=0, quotient=0, remainder=0,
//    div_by_zero=0, iteration counter=0.
//  - Reset mid-operation: reset_n low aborts any division immediately; no done is
//    issued for the aborted request.
//  - Clock enable: every register advances only when ce=1. While ce=0, done keeps its
//    current level; the pulse lasts one enabled cycle.
//  - States: IDLE, BUSY, DONE.
//    - IDLE --accept--> BUSY, or DONE if divisor==0.
//    - BUSY --counter reaches DIVIDEND_WIDTH-1--> DONE.
//    - DONE --next enabled cycle--> IDLE, or BUSY/DONE if start is accepted
//      (back-to-back operation).
//  - Accept: load the dividend into the shift register, clear the partial remainder
//    (DIVISOR_WIDTH+1 bits), latch the divisor, clear the counter.
//  - BUSY step, MSB first:
//    - p = {rem, next dividend bit}.
//    - If p >= divisor: rem = p - divisor and the quotient bit is 1.
//    - Otherwise: rem = p and the quotient bit is 0.
//    - All compares and subtracts are unsigned at DIVISOR_WIDTH+1 bits; no truncation
//      before the compare.
//  - Latency: accept at edge N -> done=1 after edge N+DIVIDEND_WIDTH+1 (64 enabled
//    cycles with defaults). Counted in enabled cycles when ce toggles.
//  - Outputs quotient, remainder and div_by_zero update only on entry to DONE and are
//    stable otherwise.
//  - start while BUSY: ignored; no queuing; the in-flight result is unaffected.
//  - Divisor 0: DONE on the next enabled cycle with
//    quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], div_by_zero = 1.
//  - div_by_zero clears on the next accept.
//  - Dividend < divisor: quotient=0, remainder=dividend, full latency (no early exit).
// TESTING
//  1. Nominal: dividend=100, divisor=7 -> done exactly 64 cycles after accept;
//     quotient=14, remainder=2.
//  2. Extremes: dividend=2^63-1, divisor=2^31-1 -> quotient=0x1_0000_0002, remainder=1;
//     divisor=1 -> quotient=dividend, remainder=0.
//  3. Divide by zero: dividend=0x55, divisor=0 -> done 1 cycle after accept,
//     div_by_zero=1, quotient=all ones, remainder=0x55.
//  4. Handshake: start held high through BUSY -> exactly one done;
//     start asserted in DONE -> new operation accepted with no IDLE gap.
//  5. ce stall: ce=0 for 10 cycles mid-division -> done delayed by exactly 10 cycles;
//     result unchanged (1000/33 -> quotient=30, remainder=10).
//  6. Reset mid-op: reset_n low at iteration 20 -> outputs at reset values immediately;
//     ready=1; no done; next request completes correctly.

Source files
------------

// File: rtl/maxpool_cif_udiv_seq.sv
// Sequential unsigned restoring divider, one quotient bit per enabled cycle.
// Splits a flat feature-map index into row (quotient) and column (remainder).
module maxpool_cif_udiv_seq #(
  parameter int DIVIDEND_WIDTH = 63,
  parameter int DIVISOR_WIDTH  = 31
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      ready,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int NW = DIVIDEND_WIDTH;
  localparam int DW = DIVISOR_WIDTH;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] sh_q, sh_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic          z_q, z_d;
  logic          done_q, done_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [DW-1:0] remo_q, remo_d;
  logic          dbz_q, dbz_d;

  logic [DW:0]   p;
  logic          ge;
  logic [DW-1:0] diff;
  logic          accept;

  // Remainder stays below the divisor, so the low bits of p - divisor
  // are the whole difference whenever p >= divisor.
  always_comb begin
    p      = {rem_q, sh_q[NW-1]};
    ge     = (p >= {1'b0, dvs_q});
    diff   = p[DW-1:0] - dvs_q;
    accept = start && (state_q != S_BUSY);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    z_d     = z_q;
    done_d  = done_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    if (ce) begin
      done_d = (state_q == S_DONE);
      if (state_q == S_DONE) begin
        quo_d  = z_q ? '1 : sh_q;
        remo_d = z_q ? sh_q[DW-1:0] : rem_q;
        dbz_d  = z_q;
      end
      unique case (state_q)
        S_BUSY: begin
          sh_d  = {sh_q[NW-2:0], ge};
          rem_d = ge ? diff : p[DW-1:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      if (accept) begin
        sh_d    = dividend;
        rem_d   = '0;
        dvs_d   = divisor;
        cnt_d   = '0;
        z_d     = (divisor == '0);
        state_d = (divisor == '0) ? S_DONE : S_BUSY;
        if (state_q == S_IDLE) begin
          dbz_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      z_q     <= z_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q != S_BUSY);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_maxpool_cif_udiv_seq.sv
// Bench for maxpool_cif_udiv_seq: directed cases plus random traffic
// checked every cycle against a result-queue model.
module tb_maxpool_cif_udiv_seq;

  localparam int NW  = 63;
  localparam int DW  = 31;
  localparam int LAT = NW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic          start;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  int total = 0;
  int bad   = 0;

  maxpool_cif_udiv_seq #(
    .DIVIDEND_WIDTH(NW),
    .DIVISOR_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: each accepted request becomes a result due a fixed
  // number of enabled edges later.
  typedef struct {
    longint unsigned due;
    logic [NW-1:0]   q;
    logic [DW-1:0]   r;
    bit              z;
  } res_t;

  res_t            pend[$];
  longint unsigned ecyc   = 0;
  longint unsigned acc_e  = 0;
  longint unsigned acc_l  = 0;
  bit              have_op = 0;
  logic            m_ready = 1'b1;
  logic            m_done  = 1'b0;
  logic [NW-1:0]   m_q     = '0;
  logic [DW-1:0]   m_r     = '0;
  logic            m_z     = 1'b0;

  function automatic bit busy_at(input longint unsigned k);
    return have_op && (k >= acc_e) && (k + 1 < acc_e + acc_l);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend.delete();
      ecyc    = 0;
      have_op = 0;
      m_ready = 1'b1;
      m_done  = 1'b0;
      m_q     = '0;
      m_r     = '0;
      m_z     = 1'b0;
    end else if (ce) begin : step
      bit              acc;
      bit              fin;
      res_t            n;
      longint unsigned a;
      longint unsigned b;
      acc  = start && !busy_at(ecyc);
      ecyc = ecyc + 1;
      fin  = 0;
      if (pend.size() > 0 && pend[0].due == ecyc) begin
        n   = pend.pop_front();
        fin = 1;
        m_q = n.q;
        m_r = n.r;
        m_z = n.z;
      end
      m_done = fin;
      if (acc) begin
        a = {1'b0, dividend};
        b = {33'd0, divisor};
        if (b == 0) begin
          n.q   = '1;
          n.r   = dividend[DW-1:0];
          n.z   = 1;
          acc_l = 1;
        end else begin
          n.q   = NW'(a / b);
          n.r   = DW'(a % b);
          n.z   = 0;
          acc_l = LAT;
        end
        n.due   = ecyc + acc_l;
        pend.push_back(n);
        acc_e   = ecyc;
        have_op = 1;
        if (!fin) m_z = 1'b0;
      end
      m_ready = !busy_at(ecyc);
    end
  end

  always @(negedge clk) begin
    chk("cmp_ready", {63'd0, ready}, {63'd0, m_ready});
    chk("cmp_done", {63'd0, done}, {63'd0, m_done});
    chk("cmp_quot", {1'b0, quotient}, {1'b0, m_q});
    chk("cmp_rem", {33'd0, remainder}, {33'd0, m_r});
    chk("cmp_dbz", {63'd0, div_by_zero}, {63'd0, m_z});
  end

  task automatic issue(input logic [NW-1:0] a, input logic [DW-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int stall_at,
                           input int stall_len, output int edges);
    bit found = 0;
    edges = -1;
    for (int n = 1; n <= limit && !found; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = n;
        found = 1;
      end
      #1;
      if (n == stall_at) ce = 1'b0;
      if (n == stall_at + stall_len) ce = 1'b1;
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) cnt++;
      #1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int dn;
    int rn;
    reset_n  = 1'b0;
    ce       = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quot", {1'b0, quotient}, 64'd0);
    chk("rst_rem", {33'd0, remainder}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    issue(63'd100, 31'd7);
    wait_done(200, 0, 0, e);
    chk("nom_lat", 64'(e), 64'd64);
    chk("nom_quot", {1'b0, quotient}, 64'd14);
    chk("nom_rem", {33'd0, remainder}, 64'd2);
    chk("nom_dbz", {63'd0, div_by_zero}, 64'd0);

    issue(63'h7FFF_FFFF_FFFF_FFFF, 31'h7FFF_FFFF);
    wait_done(200, 0, 0, e);
    chk("max_lat", 64'(e), 64'd64);
    chk("max_quot", {1'b0, quotient}, 64'h1_0000_0002);
    chk("max_rem", {33'd0, remainder}, 64'd1);

    issue(63'h1234_5678_9ABC_DEF0, 31'd1);
    wait_done(200, 0, 0, e);
    chk("one_quot", {1'b0, quotient}, 64'h1234_5678_9ABC_DEF0);
    chk("one_rem", {33'd0, remainder}, 64'd0);

    issue(63'd5, 31'd1000);
    wait_done(200, 0, 0, e);
    chk("small_lat", 64'(e), 64'd64);
    chk("small_quot", {1'b0, quotient}, 64'd0);
    chk("small_rem", {33'd0, remainder}, 64'd5);

    issue(63'h55, 31'd0);
    wait_done(200, 0, 0, e);
    chk("dz_lat", 64'(e), 64'd1);
    chk("dz_flag", {63'd0, div_by_zero}, 64'd1);
    chk("dz_quot", {1'b0, quotient}, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("dz_rem", {33'd0, remainder}, 64'h55);

    start    = 1'b1;
    dividend = 63'd500;
    divisor  = 31'd9;
    @(posedge clk);
    repeat (63) @(posedge clk);
    #2;
    start = 1'b0;
    count_done(100, dn);
    chk("hold_one_done", 64'(dn), 64'd1);
    chk("hold_quot", {1'b0, quotient}, 64'd55);
    chk("hold_rem", {33'd0, remainder}, 64'd5);
    chk("hold_dbz", {63'd0, div_by_zero}, 64'd0);

    issue(63'd100, 31'd7);
    rn = -1;
    for (int n = 1; n <= 100 && rn < 0; n++) begin
      @(posedge clk);
      #2;
      if (ready === 1'b1) rn = n;
    end
    chk("b2b_ready_edge", 64'(rn), 64'd63);
    start    = 1'b1;
    dividend = 63'd1000;
    divisor  = 31'd33;
    @(posedge clk);
    #1;
    chk("b2b_done", {63'd0, done}, 64'd1);
    chk("b2b_no_idle", {63'd0, ready}, 64'd0);
    chk("b2b_quot1", {1'b0, quotient}, 64'd14);
    #1;
    start = 1'b0;
    wait_done(200, 0, 0, e);
    chk("b2b_lat2", 64'(e), 64'd64);
    chk("b2b_quot2", {1'b0, quotient}, 64'd30);
    chk("b2b_rem2", {33'd0, remainder}, 64'd10);

    issue(63'd1000, 31'd33);
    wait_done(200, 20, 10, e);
    chk("stall_lat", 64'(e), 64'd74);
    chk("stall_quot", {1'b0, quotient}, 64'd30);
    chk("stall_rem", {33'd0, remainder}, 64'd10);

    issue(63'd77777, 31'd123);
    repeat (20) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'd0, ready}, 64'd1);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_quot", {1'b0, quotient}, 64'd0);
    chk("mid_rst_rem", {33'd0, remainder}, 64'd0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    count_done(80, dn);
    chk("mid_rst_no_done", 64'(dn), 64'd0);
    issue(63'd1000, 31'd33);
    wait_done(200, 0, 0, e);
    chk("post_rst_lat", 64'(e), 64'd64);
    chk("post_rst_quot", {1'b0, quotient}, 64'd30);
    chk("post_rst_rem", {33'd0, remainder}, 64'd10);

    for (int n = 0; n < 4000; n++) begin
      int mode;
      @(posedge clk);
      #2;
      mode  = int'($urandom % 8);
      ce    = ($urandom % 8) != 0;
      start = ($urandom % 3) == 0;
      dividend = NW'({$urandom, $urandom});
      unique case (mode)
        0: divisor = '0;
        1: divisor = 31'd1;
        2: divisor = DW'($urandom % 100 + 1);
        3: begin
          dividend = NW'($urandom % 1000);
          divisor  = DW'($urandom % 2000 + 1);
        end
        default: divisor = DW'($urandom);
      endcase
    end
    start = 1'b0;
    ce    = 1'b1;
    repeat (80) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
